// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-register EX/WB pipeline around an external combinational ALU.
// Define ALU_EXEC_SKID_EN to add a one-entry skid buffer and a registered disp_ready.
module alu_exec_stage #(
    parameter int WORD_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [3:0]        disp_aluop,
    input  logic [WORD_W-1:0] disp_a,
    input  logic [WORD_W-1:0] disp_b,
    input  logic [TAG_W-1:0]  disp_tag,
    output logic [3:0]        alu_aluop,
    output logic [WORD_W-1:0] alu_port_a,
    output logic [WORD_W-1:0] alu_port_b,
    input  logic [WORD_W-1:0] alu_port_output,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WORD_W-1:0] wb_result,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_negative,
    output logic              wb_overflow,
    output logic              wb_zero
);
    logic              ex_valid;
    logic [3:0]        ex_aluop;
    logic [WORD_W-1:0] ex_a;
    logic [WORD_W-1:0] ex_b;
    logic [TAG_W-1:0]  ex_tag;
    logic              wb_free;
    logic              adv;
    logic              ex_open;
    logic              accept;

    assign wb_free    = !wb_valid || wb_ready;
    assign adv        = ex_valid && wb_free;
    assign ex_open    = !ex_valid || wb_free;
    assign accept     = disp_valid && disp_ready;
    assign alu_aluop  = ex_valid ? ex_aluop : '0;
    assign alu_port_a = ex_valid ? ex_a : '0;
    assign alu_port_b = ex_valid ? ex_b : '0;

`ifdef ALU_EXEC_SKID_EN
    logic              skid_valid;
    logic [3:0]        skid_aluop;
    logic [WORD_W-1:0] skid_a;
    logic [WORD_W-1:0] skid_b;
    logic [TAG_W-1:0]  skid_tag;

    assign disp_ready = nRST && !skid_valid && !flush;

    // the skid always drains into EX before any new dispatch, keeping program order
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid   <= 1'b0;
            ex_aluop   <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_tag     <= '0;
            skid_valid <= 1'b0;
            skid_aluop <= '0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (ex_open) begin
                ex_valid   <= 1'b1;
                ex_aluop   <= skid_aluop;
                ex_a       <= skid_a;
                ex_b       <= skid_b;
                ex_tag     <= skid_tag;
                skid_valid <= 1'b0;
            end
        end else if (accept && ex_open) begin
            ex_valid <= 1'b1;
            ex_aluop <= disp_aluop;
            ex_a     <= disp_a;
            ex_b     <= disp_b;
            ex_tag   <= disp_tag;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_aluop <= disp_aluop;
            skid_a     <= disp_a;
            skid_b     <= disp_b;
            skid_tag   <= disp_tag;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end
`else
    assign disp_ready = nRST && ex_open && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid <= 1'b0;
            ex_aluop <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_tag   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_aluop <= disp_aluop;
            ex_a     <= disp_a;
            ex_b     <= disp_b;
            ex_tag   <= disp_tag;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid    <= 1'b0;
            wb_result   <= '0;
            wb_tag      <= '0;
            wb_negative <= 1'b0;
            wb_overflow <= 1'b0;
            wb_zero     <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (adv) begin
            wb_valid    <= 1'b1;
            wb_result   <= alu_port_output;
            wb_tag      <= ex_tag;
            wb_negative <= alu_negative;
            wb_overflow <= alu_overflow;
            wb_zero     <= alu_zero;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage with a small behavioural ALU.
module tb_alu_exec_stage;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_aluop = '0;
    logic [31:0] disp_a = '0;
    logic [31:0] disp_b = '0;
    logic [5:0]  disp_tag = '0;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_port_a;
    logic [31:0] alu_port_b;
    logic [31:0] alu_port_output;
    logic        alu_negative;
    logic        alu_overflow;
    logic        alu_zero;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_result;
    logic [5:0]  wb_tag;
    logic        wb_negative;
    logic        wb_overflow;
    logic        wb_zero;

    typedef struct packed {
        logic [31:0] r;
        logic [5:0]  t;
        logic        n;
        logic        o;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t alu_now;
    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;

    // op 0 add, op 1 xor, op 15 passes a through and reports overflow
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] tag);
        exp_t e;
        e.r = (op == 4'd0) ? a + b : (op == 4'd1) ? a ^ b : a;
        e.t = tag;
        e.n = e.r[31];
        e.z = (e.r == 32'd0);
        e.o = (op == 4'd15) ? 1'b1 : (op == 4'd0) ? ((a[31] == b[31]) && (e.r[31] != a[31])) : 1'b0;
        return e;
    endfunction

    assign alu_now         = model(alu_aluop, alu_port_a, alu_port_b, 6'd0);
    assign alu_port_output = alu_now.r;
    assign alu_negative    = alu_now.n;
    assign alu_overflow    = alu_now.o;
    assign alu_zero        = alu_now.z;

    alu_exec_stage #(.WORD_W(32), .TAG_W(6)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_aluop(disp_aluop), .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag),
        .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
        .alu_port_output(alu_port_output), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_tag(wb_tag),
        .wb_negative(wb_negative), .wb_overflow(wb_overflow), .wb_zero(wb_zero)
    );

    always #5 CLK = ~CLK;

    // scoreboard: compare on WB handshake, push on dispatch handshake, drop everything on flush/reset
    always @(negedge CLK) begin
        if (!nRST) begin
            sb.delete();
        end else begin
            if (wb_valid && wb_ready) begin
                vectors++;
                pops++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got result=%h tag=%0d, required no output", wb_result, wb_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({wb_result, wb_tag, wb_negative, wb_overflow, wb_zero} !== e) begin
                        miscompares++;
                        $display("FAIL sb_result: got r=%h t=%0d n%b o%b z%b, required r=%h t=%0d n%b o%b z%b",
                                 wb_result, wb_tag, wb_negative, wb_overflow, wb_zero, e.r, e.t, e.n, e.o, e.z);
                    end
                end
            end
            if (disp_valid && disp_ready && !flush)
                sb.push_back(model(disp_aluop, disp_a, disp_b, disp_tag));
            if (flush)
                sb.delete();
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        int n;
        n = 0;
        disp_aluop = op;
        disp_a     = a;
        disp_b     = b;
        disp_tag   = tag;
        disp_valid = 1'b1;
        @(negedge CLK);
        while (!disp_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!disp_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got disp_ready=0 for 50 cycles, required 1");
        end
        @(posedge CLK);
        #1;
        disp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({wb_valid, disp_ready, wb_result, wb_tag, alu_aluop} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got wb_valid=%b disp_ready=%b wb_result=%h alu_aluop=%h, required all 0",
                     wb_valid, disp_ready, wb_result, alu_aluop);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        vectors++;
        if (disp_ready !== 1'b1 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got disp_ready=%b wb_valid=%b, required 1 0", disp_ready, wb_valid);
        end
    endtask

    task automatic test_basic();
        wb_ready = 1'b1;
        @(posedge CLK);
        #1;
        disp_aluop = 4'd0;
        disp_a     = 32'd5;
        disp_b     = 32'd7;
        disp_tag   = 6'd9;
        disp_valid = 1'b1;
        @(posedge CLK);
        #1;
        disp_valid = 1'b0;
        vectors++;
        if (alu_port_a !== 32'd5 || alu_port_b !== 32'd7 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ex: got a=%0d b=%0d wb_valid=%b, required 5 7 0", alu_port_a, alu_port_b, wb_valid);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_result !== 32'd12 || wb_zero !== 1'b0 || wb_tag !== 6'd9) begin
            miscompares++;
            $display("FAIL basic_wb: got v=%b r=%0d z=%b t=%0d, required 1 12 0 9", wb_valid, wb_result, wb_zero, wb_tag);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b0 || alu_port_a !== 32'd0 || alu_port_b !== 32'd0 || alu_aluop !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_idle: got wb_valid=%b alu_a=%h alu_b=%h op=%h, required all 0",
                     wb_valid, alu_port_a, alu_port_b, alu_aluop);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pops;
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            disp_valid = (i < 4);
            disp_aluop = 4'(i % 2);
            disp_a     = 32'(1000 * (i + 1));
            disp_b     = 32'(i + 3);
            disp_tag   = 6'(30 + i);
            if (i >= 2) begin
                vectors++;
                if (wb_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_stream_%0d: got wb_valid=%b, required 1", i, wb_valid);
                end
            end
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b0 || pops - p0 !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got wb_valid=%b outputs=%0d, required 0 4", wb_valid, pops - p0);
        end
    endtask

    task automatic test_stall();
        int   k;
        int   exp_acc;
        logic acc;
        exp_t e0;
`ifdef ALU_EXEC_SKID_EN
        exp_acc = 3;
`else
        exp_acc = 2;
`endif
        k = 0;
        e0 = model(4'd0, 32'd100, 32'd1, 6'd20);
        wb_ready   = 1'b0;
        disp_aluop = 4'd0;
        disp_a     = 32'd100;
        disp_b     = 32'd1;
        disp_tag   = 6'd20;
        disp_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            acc = disp_ready;
            @(posedge CLK);
            #1;
            if (acc) begin
                k++;
                disp_valid = (k < 3);
                disp_a     = 32'(100 * (k + 1));
                disp_b     = 32'(k + 1);
                disp_tag   = 6'(20 + k);
            end
            if (c >= 1) begin
                vectors++;
                if (wb_valid !== 1'b1 || wb_result !== e0.r || wb_tag !== e0.t) begin
                    miscompares++;
                    $display("FAIL stall_hold_%0d: got v=%b r=%0d t=%0d, required 1 %0d %0d",
                             c, wb_valid, wb_result, wb_tag, e0.r, e0.t);
                end
            end
        end
        vectors++;
        if (k !== exp_acc || disp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_accepts: got accepts=%0d disp_ready=%b, required %0d 0", k, disp_ready, exp_acc);
        end
        wb_ready = 1'b1;
        if (k < 3)
            send(4'd0, 32'd300, 32'd3, 6'd22);
        wait_drain();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_flags();
        wb_ready = 1'b1;
        send(4'd15, 32'h8000_0000, 32'd0, 6'd11);
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_result !== 32'h8000_0000 || wb_negative !== 1'b1 || wb_overflow !== 1'b1 || wb_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL flags_ovf: got v=%b r=%h n%b o%b z%b, required 1 80000000 n1 o1 z0",
                     wb_valid, wb_result, wb_negative, wb_overflow, wb_zero);
        end
        send(4'd1, 32'h1234_5678, 32'h1234_5678, 6'd12);
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_result !== 32'd0 || wb_negative !== 1'b0 || wb_overflow !== 1'b0 || wb_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_zero: got v=%b r=%h n%b o%b z%b, required 1 0 n0 o0 z1",
                     wb_valid, wb_result, wb_negative, wb_overflow, wb_zero);
        end
        wait_drain();
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        wb_ready = 1'b0;
        send(4'd0, 32'd50, 32'd1, 6'd1);
        send(4'd0, 32'd60, 32'd2, 6'd2);
        disp_aluop = 4'd0;
        disp_a     = 32'd70;
        disp_b     = 32'd3;
        disp_tag   = 6'd63;
        disp_valid = 1'b1;
        flush      = 1'b1;
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || alu_port_a !== 32'd60 || disp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pre: got wb_valid=%b ex_a=%0d disp_ready=%b, required 1 60 0",
                     wb_valid, alu_port_a, disp_ready);
        end
        @(posedge CLK);
        #1;
        flush      = 1'b0;
        disp_valid = 1'b0;
        vectors++;
        if (wb_valid !== 1'b0 || alu_port_a !== 32'd0 || alu_aluop !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_clear: got wb_valid=%b alu_a=%h op=%h, required 0 0 0", wb_valid, alu_port_a, alu_aluop);
        end
        wb_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (wb_valid)
                seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL flush_dropped: got %0d outputs after flush, required 0", seen);
        end
    endtask

    task automatic test_async_reset();
        wb_ready = 1'b0;
        send(4'd0, 32'd77, 32'd1, 6'd40);
        @(posedge CLK);
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_result !== 32'd78) begin
            miscompares++;
            $display("FAIL areset_pre: got v=%b r=%0d, required 1 78", wb_valid, wb_result);
        end
        #2;
        nRST = 1'b0;
        #1;
        vectors++;
        if (wb_valid !== 1'b0 || wb_result !== 32'd0 || wb_tag !== 6'd0 || disp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_now: got v=%b r=%h t=%0d ready=%b, required 0 0 0 0", wb_valid, wb_result, wb_tag, disp_ready);
        end
        #3;
        nRST = 1'b1;
        #1;
        vectors++;
        if (disp_ready !== 1'b1 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_release: got ready=%b v=%b, required 1 0", disp_ready, wb_valid);
        end
        wb_ready = 1'b1;
        send(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd41);
        wait_drain();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL areset_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_flags();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the operand/result width (matches word_t).
REQ-002 SHALL have parameter TAG_W, default 6, the width of the op tag carried to writeback.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous kill of all in-flight ops.
REQ-006 SHALL have port disp_valid  input  1  dispatch offers an op.
REQ-007 SHALL have port disp_ready  output  1  stage accepts the op this cycle.
REQ-008 SHALL have ports disp_aluop (input, 4), disp_a and disp_b (input, WORD_W), disp_tag (input, TAG_W): the op fields.
REQ-009 SHALL have ports alu_aluop (output, 4) and alu_port_a, alu_port_b (output, WORD_W): drive the combinational ALU.
REQ-010 SHALL have ports alu_port_output (input, WORD_W) and alu_negative, alu_overflow, alu_zero (input, 1 each): ALU results.
REQ-011 SHALL have ports wb_valid  output  1, and wb_ready  input  1: the writeback handshake.
REQ-012 SHALL have ports wb_result (output, WORD_W), wb_tag (output, TAG_W), and wb_negative, wb_overflow, wb_zero (output, 1 each): the registered results.

Function
REQ-013 SHALL hold two registered stages: EX (op being computed) and WB (result awaiting consumer); each has a valid bit.
REQ-014 SHALL drive alu_aluop/alu_port_a/alu_port_b from the EX register every cycle.
REQ-015 SHALL drive the alu_* ALU-driving outputs to 0 when EX is invalid.
REQ-016 SHALL transfer a dispatch on a cycle with disp_valid && disp_ready; the transfer fires at the clock edge.
REQ-017 SHALL define wb_free = !wb_valid || wb_ready.
REQ-018 SHALL advance EX->WB when EX is valid and wb_free: capture alu_port_output, flags and tag into WB.
REQ-019 SHALL clear wb_valid on a WB handshake (wb_valid && wb_ready) when there is no simultaneous EX->WB advance.
REQ-020 SHALL, on a simultaneous WB handshake and EX->WB advance, replace WB with the new result with wb_valid staying 1.
REQ-021 SHALL hold the WB outputs stable while wb_valid && !wb_ready.
REQ-022 SHALL have a latency of 2 edges: op accepted at edge N is visible on wb_* after edge N+1.
REQ-023 SHALL sustain one op per cycle when wb_ready is held at 1.
REQ-024 SHALL, when flush=1, clear the EX, WB and skid valid bits at the edge and force disp_ready=0 that cycle; any dispatch that cycle is dropped.
REQ-025 SHALL let flush take priority over every simultaneous handshake.
REQ-026 SHALL pass data unmodified: no width change; the aluop encoding is opaque to this block.

Reset
REQ-027 SHALL, while nRST=0, asynchronously clear all valid bits and the skid buffer.
REQ-028 SHALL, while nRST=0, clear wb_result, wb_tag and the flags to 0, and drive disp_ready=0.
REQ-029 SHALL, on the first cycle after nRST deasserts, drive disp_ready=1 with both stages empty; an op in flight at reset is lost.

Configuration
REQ-030 SHALL compile a one-entry skid buffer in front of EX when macro ALU_EXEC_SKID_EN is defined.
REQ-031 SHALL, with ALU_EXEC_SKID_EN defined, make disp_ready registered: disp_ready = !skid_valid.
- When EX is stalled (valid && !wb_free), an accepted op goes into the skid.
- When the skid is valid, EX is refilled from the skid before new dispatch.
- Program order is preserved.
REQ-032 SHALL, without ALU_EXEC_SKID_EN, have no skid and a combinational disp_ready = !ex_valid || wb_free.

Verification
REQ-033 SHALL cover: a=5,b=7, ALU model returns a+b=12, wb_ready=1 -> wb_valid after edge N+1, wb_result=12, zero=0, tag echoed.
REQ-034 SHALL cover: 4 back-to-back ops, wb_ready=1 -> 4 consecutive wb_valid cycles, results in dispatch order.
REQ-035 SHALL cover: wb_ready=0 for 5 cycles with 3 ops offered -> WB holds op0 stable.
- Without skid: disp_ready=0 after 2 accepts.
- With skid: disp_ready=0 after 3 accepts.
- All ops later drain in order.
REQ-036 SHALL cover: ALU model returns 0x80000000 with overflow=1 -> wb_negative=1, wb_overflow=1, wb_zero=0.
REQ-037 SHALL cover: flush asserted while EX and WB are valid and disp_valid=1 -> next cycle wb_valid=0, and the dispatched op never appears.
REQ-038 SHALL cover: nRST pulsed low mid-stream without a clock edge -> wb_valid=0 and wb_result=0 immediately, and disp_ready=1 after release.
